// File: rtl/clk_lock_seq.sv
// Clock lock sequencer.
// Each channel holds its PLL/DCM in reset, waits for lock, waits for the lock
// to stay stable, and only then releases the reset of the logic clocked by that
// channel. A failed lock attempt or a lost lock counts as a retry, and the
// channel starts over from the PLL reset. A cascaded channel follows the
// channel below it: it starts only once that channel is running and drops back
// into PLL reset whenever that channel stops running.
module clk_lock_seq #(
    parameter int              N_CH          = 4,
    parameter int              RST_CYCLES    = 16,
    parameter int              LOCK_TIMEOUT  = 65535,
    parameter int              SETTLE_CYCLES = 1024,
    parameter logic [N_CH-1:0] CASCADE       = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_CH-1:0]   LOCKED,
    input  logic [N_CH-1:0]   ENABLE,
    input  logic              CLR_RETRIES,
    output logic [N_CH-1:0]   PLL_RST,
    output logic [N_CH-1:0]   DOMAIN_RST,
    output logic [N_CH-1:0]   READY,
    output logic              ALL_READY,
    output logic [4*N_CH-1:0] RETRIES,
    output logic [3*N_CH-1:0] dbg_state
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_HOLD      = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    // Timer values on which each timed state ends.
    localparam logic [19:0] HOLD_LAST   = 20'(RST_CYCLES - 1);
    localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYCLES - 1);
    // Channel 0 has no upstream channel, so its cascade bit is dropped.
    localparam logic [N_CH-1:0] CASCADE_EFF = CASCADE & ~(N_CH'(1));

    state_t          state     [N_CH];
    state_t          state_nxt [N_CH];
    logic [19:0]     timer     [N_CH];
    logic [19:0]     timer_nxt [N_CH];
    logic [3:0]      retry     [N_CH];
    logic [3:0]      retry_nxt [N_CH];
    logic [N_CH-1:0] lock_m;
    logic [N_CH-1:0] lock_s;
    logic [N_CH-1:0] up_ready;
    logic [N_CH-1:0] forced;
    logic [N_CH-1:0] bump;

    // Two-flop synchronizer for the asynchronous lock indications.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lock_m <= '0;
            lock_s <= '0;
        end else begin
            lock_m <= LOCKED;
            lock_s <= lock_m;
        end
    end

    // Registered READY of the channel below each channel (none for channel 0).
    always_comb begin
        up_ready = '0;
        for (int i = 1; i < N_CH; i++) begin
            up_ready[i] = READY[i-1];
        end
    end

    // Per-channel next state, timer and retry counter.
    always_comb begin
        forced = '0;
        bump   = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_nxt[i] = state[i];
            if (!ENABLE[i]) begin
                state_nxt[i] = S_OFF;
            end else if (CASCADE_EFF[i] && state[i] != S_OFF && !up_ready[i]) begin
                // Upstream clock is not trustworthy: keep this PLL in reset and
                // restart its hold time, without counting it as a retry.
                state_nxt[i] = S_HOLD;
                forced[i]    = 1'b1;
            end else begin
                case (state[i])
                    S_OFF: begin
                        if (!CASCADE_EFF[i] || up_ready[i]) state_nxt[i] = S_HOLD;
                    end
                    S_HOLD: begin
                        if (timer[i] == HOLD_LAST) state_nxt[i] = S_WAIT_LOCK;
                    end
                    S_WAIT_LOCK: begin
                        if (lock_s[i]) begin
                            state_nxt[i] = S_SETTLE;
                        end else if (timer[i] == LOCK_LAST) begin
                            state_nxt[i] = S_HOLD;
                            bump[i]      = 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (!lock_s[i]) begin
                            state_nxt[i] = S_WAIT_LOCK;
                        end else if (timer[i] == SETTLE_LAST) begin
                            state_nxt[i] = S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (!lock_s[i]) begin
                            state_nxt[i] = S_HOLD;
                            bump[i]      = 1'b1;
                        end
                    end
                    default: state_nxt[i] = S_OFF;
                endcase
            end

            // Timer restarts on every state entry; untimed states keep it at 0.
            if (forced[i] || state_nxt[i] != state[i] ||
                state_nxt[i] == S_OFF || state_nxt[i] == S_RUN) begin
                timer_nxt[i] = '0;
            end else begin
                timer_nxt[i] = timer[i] + 20'd1;
            end

            // Clear beats a simultaneous increment; the count saturates at 15.
            if (CLR_RETRIES) begin
                retry_nxt[i] = '0;
            end else if (bump[i] && retry[i] != 4'hF) begin
                retry_nxt[i] = retry[i] + 4'd1;
            end else begin
                retry_nxt[i] = retry[i];
            end
        end
    end

    // State, timers, counters and outputs registered from the next state.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= S_OFF;
                timer[i] <= '0;
                retry[i] <= '0;
            end
            PLL_RST    <= '1;
            DOMAIN_RST <= '1;
            READY      <= '0;
            ALL_READY  <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state[i]      <= state_nxt[i];
                timer[i]      <= timer_nxt[i];
                retry[i]      <= retry_nxt[i];
                PLL_RST[i]    <= (state_nxt[i] == S_OFF) || (state_nxt[i] == S_HOLD);
                DOMAIN_RST[i] <= (state_nxt[i] != S_RUN);
                READY[i]      <= (state_nxt[i] == S_RUN);
            end
            ALL_READY <= (|ENABLE) && (&(READY | ~ENABLE));
        end
    end

    // Flatten retry counters and per-channel state onto output buses.
    always_comb begin
        RETRIES   = '0;
        dbg_state = '0;
        for (int i = 0; i < N_CH; i++) begin
            RETRIES[4*i +: 4]   = retry[i];
            dbg_state[3*i +: 3] = state[i];
        end
    end

endmodule

// File: doc/clk_lock_seq.md
CLK_LOCK_SEQ -- requirements
Module: clk_lock_seq

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of PLL/DCM channels sequenced.
REQ-002 SHALL have parameter RST_CYCLES, default 16: PLL reset hold length in CLK cycles (1..2^20-1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: cycles allowed for lock after PLL reset release (1..2^20-1).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 1024: cycles LOCKED must stay stable before the domain is released (1..2^20-1).
REQ-005 SHALL have parameter CASCADE, default 0, N_CH bits: bit i set means channel i's input clock comes from channel i-1; bit 0 is ignored.
REQ-006 CLK  in  1  single clock for all logic (48 MHz board clock).
REQ-007 RST_N  in  1  reset, synchronous and active-low.
REQ-008 LOCKED  in  N_CH  per-channel lock indication, asynchronous to CLK.
REQ-009 ENABLE  in  N_CH  per-channel enable, synchronous to CLK.
REQ-010 CLR_RETRIES  in  1  synchronous clear of all retry counters.
REQ-011 PLL_RST  out  N_CH  active-high reset to each PLL/DCM.
REQ-012 DOMAIN_RST  out  N_CH  active-high reset for logic clocked by each channel's output clock.
REQ-013 READY  out  N_CH  channel is in RUN.
REQ-014 ALL_READY  out  1  AND of READY over channels with ENABLE set; 0 when ENABLE is all-zero.
REQ-015 RETRIES  out  4*N_CH  per-channel saturating retry count; channel i at bits [4i+3:4i].

Function
REQ-016 Each LOCKED bit SHALL pass through a 2-flop synchronizer; FSM uses the synchronized value lock_s.
REQ-017 Each channel SHALL have an independent FSM: OFF, HOLD, WAIT_LOCK, SETTLE, RUN, plus a 20-bit timer cleared on every state entry.
REQ-018 OFF: when ENABLE[i]=1 and (CASCADE[i]=0 or READY[i-1]=1), next state SHALL be HOLD.
REQ-019 HOLD: after RST_CYCLES cycles in HOLD (timer==RST_CYCLES-1), next state SHALL be WAIT_LOCK.
REQ-020 WAIT_LOCK: lock_s=1 -> SETTLE; else on timer==LOCK_TIMEOUT-1 -> HOLD and RETRIES[i] increments.
REQ-021 SETTLE: lock_s=0 -> WAIT_LOCK with no retry increment; else on timer==SETTLE_CYCLES-1 -> RUN.
REQ-022 RUN: lock_s=0 -> HOLD and RETRIES[i] increments.
REQ-023 Priority per cycle SHALL be: ENABLE[i]=0 -> OFF; then, for CASCADE[i]=1 outside OFF, READY[i-1]=0 -> HOLD (no retry increment); then REQ-018..022.
REQ-024 Outputs SHALL be registered and track the state registered on the same edge: PLL_RST[i]=1 in OFF and HOLD; DOMAIN_RST[i]=0 only in RUN; READY[i]=1 only in RUN.
REQ-025 RETRIES SHALL saturate at 15; CLR_RETRIES=1 zeroes all counters next edge and wins over a simultaneous increment.
REQ-026 ALL_READY SHALL be registered, one cycle behind READY.

Reset
REQ-027 While RST_N=0 at an edge: all FSMs -> OFF, timers 0, synchronizers 0, PLL_RST all 1, DOMAIN_RST all 1, READY 0, ALL_READY 0, RETRIES 0.
REQ-028 Reset asserted in any state, including RUN, SHALL take effect on the next edge; after release each channel restarts from OFF.

Verification (N_CH=2, RST_CYCLES=4, LOCK_TIMEOUT=10, SETTLE_CYCLES=8)
REQ-029 Bring-up: ENABLE=01, LOCKED[0] rises and stays 1 after PLL_RST[0] falls -> PLL_RST[0] high exactly 4 cycles in HOLD; READY[0]/DOMAIN_RST[0]=1/0 after edge k+10, where k is the first edge sampling LOCKED[0]=1; ALL_READY=1 one cycle later.
REQ-030 Timeout: ENABLE=01, LOCKED=0 -> PLL_RST[0] high 4 cycles, low 10, repeating; RETRIES[3:0] = 1,2,...,15 then holds 15; CLR_RETRIES -> 0.
REQ-031 Lock loss: channel 0 in RUN, LOCKED[0] low 3 cycles -> READY[0]=0, DOMAIN_RST[0]=1, PLL_RST[0]=1 for 4 cycles, RETRIES[3:0]+1.
REQ-032 Cascade: CASCADE=10, ENABLE=11 -> PLL_RST[1] stays 1 until READY[0]=1; channel 0 lock loss -> channel 1 in HOLD on the following edge, RETRIES[7:4] unchanged.
REQ-033 Disable/clear: ENABLE[0]->0 in SETTLE -> OFF next edge, PLL_RST[0]=1; CLR_RETRIES on a timeout edge -> RETRIES[3:0]=0.
REQ-034 Reset: RST_N low 1 cycle with both channels in RUN -> all outputs at REQ-027 values; full re-sequence reproduces REQ-029 timing.
